// File: rtl/vblank_sequencer.sv
// Loadable micro-program bus master, run once per vsync period; FETCH starts one cycle after the vsync rise.
// Bus steps hold req/addr/rw/dout in BUS until bus_ack; all outputs are registered.
module vblank_sequencer #(
   parameter  int STEPS = 8,
   parameter  int NREG  = 4,
   parameter  int AW    = 16,
   parameter  int DW    = 8,
   localparam int PW    = $clog2(STEPS),
   localparam int RW    = $clog2(NREG),
   localparam int IW    = 3 + RW + AW + DW
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_vsync,
   input  logic          i_cfg_we,
   input  logic [PW-1:0] i_cfg_idx,
   input  logic [IW-1:0] i_cfg_word,
   output logic          o_bus_req,
   output logic          o_bus_rw,
   output logic [AW-1:0] o_bus_addr,
   output logic [DW-1:0] o_bus_dout,
   input  logic [DW-1:0] i_bus_din,
   input  logic          i_bus_ack,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_aborted
);

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LD   = 3'b001;
   localparam logic [2:0] OP_ST   = 3'b010;
   localparam logic [2:0] OP_STI  = 3'b011;
   localparam logic [2:0] OP_ADDI = 3'b100;

   typedef struct packed {
      logic [2:0]    op;
      logic [RW-1:0] r;
      logic [AW-1:0] addr;
      logic [DW-1:0] imm;
   } instr_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_BUS,
      S_HOLD
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic          r_vsync_q;
   logic [PW-1:0] r_pc;
   logic [PW-1:0] w_pc_nxt;
   instr_t        r_ir;
   logic [IW-1:0] r_prog [STEPS];
   logic [DW-1:0] r_regs [NREG];

   logic          w_rise;
   logic          w_last;
   logic [DW-1:0] w_reg_rd;
   logic          w_reg_we;
   logic [DW-1:0] w_reg_wdat;
   logic          w_req_nxt;
   logic          w_rw_nxt;
   logic [AW-1:0] w_addr_nxt;
   logic [DW-1:0] w_dout_nxt;
   logic          w_busy_nxt;
   logic          w_done_nxt;
   logic          w_abort_nxt;

   assign w_rise   = i_vsync & ~r_vsync_q;
   assign w_last   = (r_pc == PW'(STEPS - 1));
   assign w_reg_rd = r_regs[r_ir.r];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE:  if (w_rise) w_next_state = S_FETCH;
         S_FETCH: w_next_state = i_vsync ? S_EXEC : S_IDLE;
         S_EXEC: begin
            if (!i_vsync) begin
               w_next_state = S_IDLE;
            end else begin
               case (r_ir.op)
                  OP_NOP, OP_ADDI:      w_next_state = w_last ? S_HOLD : S_FETCH;
                  OP_LD, OP_ST, OP_STI: w_next_state = S_BUS;
                  default:              w_next_state = S_HOLD;
               endcase
            end
         end
         // The outstanding cycle always completes before an abort is honoured.
         S_BUS: begin
            if (i_bus_ack) begin
               if (!i_vsync)    w_next_state = S_IDLE;
               else if (w_last) w_next_state = S_HOLD;
               else             w_next_state = S_FETCH;
            end
         end
         S_HOLD:  if (!i_vsync) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_pc_nxt    = r_pc;
      w_req_nxt   = o_bus_req;
      w_rw_nxt    = o_bus_rw;
      w_addr_nxt  = o_bus_addr;
      w_dout_nxt  = o_bus_dout;
      w_done_nxt  = 1'b0;
      w_abort_nxt = 1'b0;
      w_reg_we    = 1'b0;
      w_reg_wdat  = w_reg_rd;
      w_busy_nxt  = (w_next_state == S_FETCH) || (w_next_state == S_EXEC) ||
                    (w_next_state == S_BUS);
      unique case (r_state)
         S_IDLE:  w_pc_nxt = '0;
         S_FETCH: w_abort_nxt = ~i_vsync;
         S_EXEC: begin
            if (!i_vsync) begin
               w_abort_nxt = 1'b1;
            end else begin
               case (r_ir.op)
                  OP_NOP: begin
                     w_pc_nxt   = r_pc + PW'(1);
                     w_done_nxt = w_last;
                  end
                  OP_ADDI: begin
                     w_pc_nxt   = r_pc + PW'(1);
                     w_done_nxt = w_last;
                     w_reg_we   = 1'b1;
                     w_reg_wdat = w_reg_rd + r_ir.imm;
                  end
                  OP_LD, OP_ST, OP_STI: begin
                     w_req_nxt  = 1'b1;
                     w_rw_nxt   = (r_ir.op != OP_LD);
                     w_addr_nxt = r_ir.addr;
                     if (r_ir.op == OP_ST)       w_dout_nxt = w_reg_rd;
                     else if (r_ir.op == OP_STI) w_dout_nxt = r_ir.imm;
                     else                        w_dout_nxt = '0;
                  end
                  default: w_done_nxt = 1'b1;
               endcase
            end
         end
         S_BUS: begin
            if (i_bus_ack) begin
               w_req_nxt   = 1'b0;
               w_rw_nxt    = 1'b0;
               w_pc_nxt    = r_pc + PW'(1);
               w_reg_we    = (r_ir.op == OP_LD);
               w_reg_wdat  = i_bus_din;
               w_abort_nxt = ~i_vsync;
               w_done_nxt  = i_vsync & w_last;
            end
         end
         S_HOLD:  w_pc_nxt = r_pc;
         default: w_pc_nxt = '0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vsync_q  <= 1'b0;
         r_pc       <= '0;
         r_ir       <= '0;
         o_bus_req  <= 1'b0;
         o_bus_rw   <= 1'b0;
         o_bus_addr <= '0;
         o_bus_dout <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_aborted  <= 1'b0;
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else begin
         r_vsync_q  <= i_vsync;
         r_pc       <= w_pc_nxt;
         o_bus_req  <= w_req_nxt;
         o_bus_rw   <= w_rw_nxt;
         o_bus_addr <= w_addr_nxt;
         o_bus_dout <= w_dout_nxt;
         o_busy     <= w_busy_nxt;
         o_done     <= w_done_nxt;
         o_aborted  <= w_abort_nxt;
         if (r_state == S_FETCH) r_ir <= r_prog[r_pc];
         if (w_reg_we) r_regs[r_ir.r] <= w_reg_wdat;
      end
   end

   // Program store has no reset; a same-cycle write leaves the fetch with the old word.
   always_ff @(posedge i_clk) begin
      if (i_cfg_we) r_prog[i_cfg_idx] <= i_cfg_word;
   end

endmodule

// File: tb/tb_vblank_sequencer.sv
// Directed bench for vblank_sequencer: expected bus cycles are queued per step and
// checked by a negedge monitor against a simple RAM model.
module tb_vblank_sequencer;
   localparam int STEPS = 8;
   localparam int NREG  = 4;
   localparam int AW    = 16;
   localparam int DW    = 8;
   localparam int PW    = 3;
   localparam int RW    = 2;
   localparam int IW    = 3 + RW + AW + DW;

   localparam logic [2:0] NOP = 3'd0, LD = 3'd1, ST = 3'd2, STI = 3'd3, ADDI = 3'd4, ENDI = 3'd5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          vsync;
   logic          cfg_we;
   logic [PW-1:0] cfg_idx;
   logic [IW-1:0] cfg_word;
   logic          bus_req;
   logic          bus_rw;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_dout;
   logic [DW-1:0] bus_din;
   logic          bus_ack;
   logic          busy;
   logic          done;
   logic          aborted;

   always #5 clk = ~clk;

   vblank_sequencer #(.STEPS(STEPS), .NREG(NREG), .AW(AW), .DW(DW)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_vsync    (vsync),
      .i_cfg_we   (cfg_we),
      .i_cfg_idx  (cfg_idx),
      .i_cfg_word (cfg_word),
      .o_bus_req  (bus_req),
      .o_bus_rw   (bus_rw),
      .o_bus_addr (bus_addr),
      .o_bus_dout (bus_dout),
      .i_bus_din  (bus_din),
      .i_bus_ack  (bus_ack),
      .o_busy     (busy),
      .o_done     (done),
      .o_aborted  (aborted)
   );

   logic [DW-1:0] ram [65536];
   assign bus_din = ram[bus_addr];
   always @(posedge clk) begin
      if (rst_n && bus_req && bus_rw && bus_ack) ram[bus_addr] <= bus_dout;
   end

   typedef struct packed {
      logic          rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] dat;
      logic [7:0]    len;
   } txn_t;

   txn_t exp_q[$];
   txn_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   abort_cnt = 0;
   int   run_len = 0;
   logic stable;
   logic cap_rw;
   logic [AW-1:0] cap_addr;
   logic [DW-1:0] cap_dout;

   int   t_done, t_abort, n_busy;
   logic b1, b2;
   int   d0, a0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
      if (!bus_req) begin
         chk("rw_low_when_idle", 32'(bus_rw), 32'd0);
         run_len = 0;
      end else begin
         if (run_len == 0) begin
            cap_addr = bus_addr;
            cap_dout = bus_dout;
            cap_rw   = bus_rw;
            stable   = 1'b1;
         end else if (bus_addr !== cap_addr || bus_dout !== cap_dout || bus_rw !== cap_rw) begin
            stable = 1'b0;
         end
         run_len++;
         if (bus_ack) begin
            checks++;
            assert (exp_q.size() > 0) else begin
               failures++;
               $error("FAIL unexpected_bus_cycle observed addr=0x%0h expected=none", bus_addr);
            end
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               chk("bus_rw", 32'(bus_rw), 32'(mon_e.rw));
               chk("bus_addr", 32'(bus_addr), 32'(mon_e.addr));
               if (mon_e.rw) chk("bus_dout", 32'(bus_dout), 32'(mon_e.dat));
               chk("req_cycles", 32'(run_len), 32'(mon_e.len));
               chk("req_stable", 32'(stable), 32'd1);
            end
            run_len = 0;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [IW-1:0] ins(input logic [2:0] op, input logic [RW-1:0] r,
                                         input logic [AW-1:0] a, input logic [DW-1:0] imm);
      return {op, r, a, imm};
   endfunction

   task automatic load(input int idx, input logic [IW-1:0] w);
      cfg_we   = 1'b1;
      cfg_idx  = PW'(idx);
      cfg_word = w;
      cyc();
      cfg_we   = 1'b0;
   endtask

   task automatic expect_txn(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int len);
      exp_q.push_back({rw, a, d, 8'(len)});
   endtask

   // vsync high for cycles 1..hi, then six low cycles; c=1 is the cycle vsync first reads high.
   task automatic run(input int hi, input int ack_lo_c, input int ack_hi_c, input int cfg_c,
                      input logic [IW-1:0] cfg_w);
      t_done = -1; t_abort = -1; n_busy = 0; b1 = 1'b0; b2 = 1'b0;
      vsync = 1'b1;
      for (int c = 1; c <= hi + 6; c++) begin
         @(negedge clk);
         if (c == 1) b1 = busy;
         if (c == 2) b2 = busy;
         if (done && t_done < 0) t_done = c;
         if (aborted && t_abort < 0) t_abort = c;
         if (busy) n_busy++;
         cyc();
         cfg_we   = (c == cfg_c);
         cfg_idx  = '0;
         cfg_word = cfg_w;
         if (c == ack_lo_c) bus_ack = 1'b0;
         if (c == ack_hi_c) bus_ack = 1'b1;
         if (c == hi) vsync = 1'b0;
      end
      cfg_we = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; vsync = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_word = '0; bus_ack = 1'b1;
      repeat (3) cyc();
      @(negedge clk);
      chk("rst_bus_req", 32'(bus_req), 0);
      chk("rst_bus_rw", 32'(bus_rw), 0);
      chk("rst_bus_addr", 32'(bus_addr), 0);
      chk("rst_bus_dout", 32'(bus_dout), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_aborted", 32'(aborted), 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // Counter program across three frames
      load(0, ins(ADDI, 2'd0, 16'h0000, 8'h01));
      load(1, ins(ST, 2'd0, 16'hEFF8, 8'h00));
      load(2, ins(ENDI, 2'd0, 16'h0000, 8'h00));
      for (int k = 1; k <= 3; k++) begin
         expect_txn(1'b1, 16'hEFF8, 8'(k), 1);
         d0 = done_cnt;
         run(20, 0, 0, 0, '0);
         chk("cnt_done_cycle", t_done, 9);
         chk("cnt_busy_cycles", n_busy, 7);
         chk("cnt_done_pulses", done_cnt - d0, 1);
         if (k == 1) begin
            chk("start_busy_n", 32'(b1), 0);
            chk("start_busy_n1", 32'(b2), 1);
         end
      end
      chk("cnt_sb_empty", exp_q.size(), 0);

      // Store, read back through RAM, store the loaded value
      load(0, ins(STI, 2'd0, 16'h0000, 8'h2A));
      load(1, ins(LD, 2'd1, 16'h0000, 8'h00));
      load(2, ins(ST, 2'd1, 16'hF005, 8'h00));
      load(3, ins(ENDI, 2'd0, 16'h0000, 8'h00));
      expect_txn(1'b1, 16'h0000, 8'h2A, 1);
      expect_txn(1'b0, 16'h0000, 8'h00, 1);
      expect_txn(1'b1, 16'hF005, 8'h2A, 1);
      run(20, 0, 0, 0, '0);
      chk("ram_done_cycle", t_done, 13);
      chk("ram_busy_cycles", n_busy, 11);
      chk("ram_sb_empty", exp_q.size(), 0);

      // Four wait states on an STI
      load(0, ins(STI, 2'd0, 16'h1234, 8'h55));
      load(1, ins(ENDI, 2'd0, 16'h0000, 8'h00));
      expect_txn(1'b1, 16'h1234, 8'h55, 5);
      run(20, 3, 7, 0, '0);
      chk("stall_done_cycle", t_done, 11);
      chk("stall_busy_cycles", n_busy, 9);
      chk("stall_sb_empty", exp_q.size(), 0);

      // All NOPs: run ends on pc wrap, once per vsync period
      for (int i = 0; i < STEPS; i++) load(i, ins(NOP, 2'd0, 16'h0000, 8'h00));
      for (int k = 0; k < 2; k++) begin
         d0 = done_cnt;
         run(30, 0, 0, 0, '0);
         chk("wrap_done_cycle", t_done, 2 * STEPS + 2);
         chk("wrap_busy_cycles", n_busy, 2 * STEPS);
         chk("wrap_done_pulses", done_cnt - d0, 1);
      end

      // vsync falls during a stalled LD
      load(0, ins(STI, 2'd0, 16'h0040, 8'h77));
      load(1, ins(LD, 2'd3, 16'h0040, 8'h00));
      load(2, ins(ST, 2'd3, 16'h0050, 8'h00));
      load(3, ins(ENDI, 2'd0, 16'h0000, 8'h00));
      expect_txn(1'b1, 16'h0040, 8'h77, 1);
      expect_txn(1'b0, 16'h0040, 8'h00, 5);
      d0 = done_cnt; a0 = abort_cnt;
      run(8, 5, 10, 0, '0);
      chk("abort_cycle", t_abort, 12);
      chk("abort_pulses", abort_cnt - a0, 1);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_busy_cycles", n_busy, 10);
      chk("abort_sb_empty", exp_q.size(), 0);
      load(0, ins(ST, 2'd3, 16'h0050, 8'h00));
      load(1, ins(ENDI, 2'd0, 16'h0000, 8'h00));
      expect_txn(1'b1, 16'h0050, 8'h77, 1);
      run(20, 0, 0, 0, '0);
      chk("abort_ld_kept_done", t_done, 7);
      chk("abort_ld_sb_empty", exp_q.size(), 0);

      // Reset asserted while a bus cycle is stalled
      load(0, ins(ST, 2'd0, 16'h0070, 8'h00));
      load(1, ins(ENDI, 2'd0, 16'h0000, 8'h00));
      bus_ack = 1'b0;
      vsync = 1'b1;
      repeat (6) cyc();
      chk("pre_reset_req", 32'(bus_req), 1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      vsync = 1'b0;
      #1;
      chk("mid_reset_req", 32'(bus_req), 0);
      chk("mid_reset_busy", 32'(busy), 0);
      chk("mid_reset_rw", 32'(bus_rw), 0);
      cyc();
      cyc();
      bus_ack = 1'b1;
      rst_n = 1'b1;
      cyc();
      for (int k = 0; k < NREG; k++) begin
         load(k, ins(ST, RW'(k), 16'h0080 + 16'(k), 8'h00));
         expect_txn(1'b1, 16'h0080 + 16'(k), 8'h00, 1);
      end
      load(NREG, ins(ENDI, 2'd0, 16'h0000, 8'h00));
      run(30, 0, 0, 0, '0);
      chk("regs_clear_done", t_done, 16);
      chk("regs_clear_sb_empty", exp_q.size(), 0);

      // ADDI wraps modulo 2^DW
      load(0, ins(ADDI, 2'd2, 16'h0000, 8'h01));
      load(1, ins(ADDI, 2'd2, 16'h0000, 8'hFF));
      load(2, ins(ST, 2'd2, 16'h0090, 8'h00));
      load(3, ins(ENDI, 2'd0, 16'h0000, 8'h00));
      expect_txn(1'b1, 16'h0090, 8'h00, 1);
      run(20, 0, 0, 0, '0);
      chk("addi_wrap_done", t_done, 11);
      chk("addi_wrap_sb_empty", exp_q.size(), 0);

      // Rewrite of the word being fetched takes effect on the next run
      load(0, ins(STI, 2'd0, 16'h00A0, 8'h11));
      load(1, ins(ENDI, 2'd0, 16'h0000, 8'h00));
      expect_txn(1'b1, 16'h00A0, 8'h11, 1);
      run(20, 0, 0, 1, ins(STI, 2'd0, 16'h00A0, 8'h22));
      chk("rbw_old_done", t_done, 7);
      chk("rbw_old_sb_empty", exp_q.size(), 0);
      expect_txn(1'b1, 16'h00A0, 8'h22, 1);
      run(20, 0, 0, 0, '0);
      chk("rbw_new_done", t_done, 7);
      chk("rbw_new_sb_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vblank_sequencer.md
# vblank_sequencer

Parametrised successor to the frame-update control unit: a small programmable bus master that runs a micro-program of up to STEPS instructions once per vertical-sync period. It drives peripheral writes and reads (text buffer, sprite registers, RAM) through the address decoder, with a req/ack handshake for wait states. It keeps NREG scratch registers that persist across frames, so counters such as position and colour survive from one frame to the next. The program is loaded at run time through a configuration port, so no RTL change is needed per game.

## Interface
- STEPS, 8: program depth in instructions; power of two, ≥2; PW = $clog2(STEPS).
- NREG, 4: scratch registers; power of two, ≥2; RW = $clog2(NREG).
- AW, 16: bus address width.
- DW, 8: bus data width.
- Instruction width IW = 3+RW+AW+DW, packed as {op[2:0], r[RW-1:0], addr[AW-1:0], imm[DW-1:0]}.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted while 0).
- vsync  in  1  vertical-blank flag, synchronous to clk.
- cfg_we  in  1  write one program word this cycle.
- cfg_idx  in  PW  program index to write.
- cfg_word  in  IW  instruction word to write.
- bus_req  out  1  bus cycle request.
- bus_rw  out  1  1 = write, 0 = read. This matches the codebase decoder convention.
- bus_addr  out  AW  bus address.
- bus_dout  out  DW  write data.
- bus_din  in  DW  read data from the decoder mux.
- bus_ack  in  1  completes the current bus cycle; may be tied high.
- busy  out  1  program running.
- done  out  1  1-cycle pulse when a program run completes normally.
- aborted  out  1  1-cycle pulse when a run is cut short by vsync falling.

## Operation
- Opcodes:
  - 000 NOP.
  - 001 LD: R[r] <= bus_din from a read at addr.
  - 010 ST: write R[r] to addr.
  - 011 STI: write imm to addr.
  - 100 ADDI: R[r] <= R[r]+imm, mod 2^DW, with no carry out.
  - 101, 110 and 111: END.
- FSM states: IDLE, FETCH, EXEC, BUS, HOLD.
  - IDLE: pc=0. Waits for a vsync rising edge, detected against a registered copy of vsync; then goes to FETCH.
  - FETCH: the registered read of prog[pc] is captured into the instruction register.
  - EXEC: decodes the instruction.
    - NOP and ADDI: pc+1, then FETCH.
    - LD, ST and STI: drive addr, rw and dout, raise bus_req, go to BUS.
    - END: pulse done, go to HOLD.
  - BUS: holds req, addr, rw and dout stable until bus_ack=1. In the ack cycle, LD captures bus_din into R[r]. Then req drops, pc+1, go to FETCH.
  - HOLD: waits for vsync=0, then IDLE. This gives exactly one run per vsync period.
- If pc wraps from STEPS-1 to 0 without an END, the run ends: done pulses, state goes to HOLD.
- If vsync falls in FETCH or EXEC, the run aborts: aborted pulses, state goes to IDLE.
  - If vsync falls during BUS, the outstanding cycle completes first (ack honoured, LD data written), then aborted pulses and the state goes to IDLE.
  - bus_req never drops before ack.
- A vsync rising edge while in HOLD or busy is ignored.
- Scratch registers keep their values across runs and are cleared only by reset.
- Program memory:
  - STEPS×IW words, written via cfg_we at any time. It is not reset and is undefined until loaded.
  - A cfg write to the index being fetched in the same cycle returns the old word (read-before-write). The new word is seen on the next fetch of that index.

## Timing
- Reset values: bus_req=0, bus_rw=0, bus_addr=0, bus_dout=0, busy=0, done=0, aborted=0, all R=0, pc=0, state IDLE, registered vsync=0.
- bus_rw=0 whenever bus_req=0.
- Start latency: vsync high in cycle N gives FETCH in N+1 and busy=1 from N+1.
- Cycles per instruction:
  - NOP/ADDI: 2 (FETCH, EXEC).
  - LD/ST/STI: 3+W, where W = cycles with bus_ack=0.
  - END: 2; done pulses in the cycle after EXEC; busy falls with it.
- ADDI result is visible to an ST issued by the next instruction.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then load 3 instructions (ADDI R0,+1; ST R0→0xEFF8; END), pulse vsync high for 20 cycles three times with ack tied high.
  - Required: three writes to 0xEFF8 with data 0x01, 0x02, 0x03.
  - Required: each write's bus_req is high exactly 1 cycle; one done pulse per vsync.
- Program: STI 0x2A→0x0000; LD 0x0000→R1; ST R1→0xF005; END. A RAM model returns the last written value.
  - Required: a write of 0x2A to 0xF005.
- With bus_ack held low for 4 cycles on an STI, check bus_req, bus_addr and bus_dout stay stable 5 cycles, and that the instruction total is 7 cycles.
- Fill all STEPS with NOP (no END).
  - Required: done at pc wrap after 2·STEPS cycles, then no further activity until vsync falls and rises again.
- Drop vsync mid-program during a stalled LD.
  - Required: the LD completes on ack and R updates, aborted pulses once, state is IDLE.
  - Required: assert reset=0 mid-BUS, then bus_req=0 immediately and R0–R3=0.
- ADDI R2,+0xFF starting from 0x01.
  - Required: R2=0x00 (wrap).
  - Required: a cfg write to the index currently being fetched executes the old word in this run and the new word in the next.
